// File: rtl/lap_ctrl.sv
// Lap controller for a stopwatch: run/pause/clear command FSM plus a small
// lap memory that stores {minutes, seconds} snapshots and replays them.
module lap_ctrl #(
  parameter int ADR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_start_stop,
  input  logic                 btn_lap,
  input  logic                 btn_clear,
  input  logic                 btn_recall,
  input  logic [7:0]           timp_s,
  input  logic [7:0]           timp_m,
  output logic [1:0]           comanda,
  output logic [7:0]           lap_s,
  output logic [7:0]           lap_m,
  output logic [ADR_WIDTH-1:0] lap_idx,
  output logic                 lap_valid,
  output logic [ADR_WIDTH:0]   lap_count,
  output logic                 full,
  output logic                 lap_drop
);

  localparam int DEPTH = 1 << ADR_WIDTH;
  localparam logic [ADR_WIDTH:0]   CNT_FULL = (ADR_WIDTH+1)'(DEPTH);
  localparam logic [ADR_WIDTH:0]   CNT_ONE  = (ADR_WIDTH+1)'(1);
  localparam logic [ADR_WIDTH:0]   CNT_ZERO = (ADR_WIDTH+1)'(0);
  localparam logic [ADR_WIDTH-1:0] PTR_ONE  = ADR_WIDTH'(1);
  localparam logic [ADR_WIDTH-1:0] PTR_ZERO = ADR_WIDTH'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b11,
    CLEAR = 2'b10
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [ADR_WIDTH-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
  logic [ADR_WIDTH:0]   lap_count_r;
  logic [15:0]          mem_r [DEPTH];
  logic [15:0]          rd_data_s;
  logic [7:0]           lap_s_r, lap_m_r;
  logic [ADR_WIDTH-1:0] lap_idx_r;
  logic                 lap_valid_r, lap_drop_r;
  logic                 full_s, clr_acc_s, ss_acc_s, store_s, drop_s, read_s;

  assign full_s    = (lap_count_r == CNT_FULL);
  assign rd_data_s = mem_r[rd_ptr_r];

  // Button arbitration: only the highest-priority pulse is considered, and
  // it is judged against the current state; CLEAR ignores every button.
  always_comb begin
    clr_acc_s = 1'b0;
    ss_acc_s  = 1'b0;
    store_s   = 1'b0;
    drop_s    = 1'b0;
    read_s    = 1'b0;
    if (state_r == CLEAR) begin
      clr_acc_s = 1'b0;
    end else if (btn_clear) begin
      clr_acc_s = 1'b1;
    end else if (btn_start_stop) begin
      ss_acc_s = 1'b1;
    end else if (btn_lap) begin
      if (state_r == RUN) begin
        store_s = !full_s;
        drop_s  = full_s;
      end else begin
        store_s = 1'b0;
      end
    end else if (btn_recall) begin
      if ((state_r != RUN) && (lap_count_r != CNT_ZERO)) begin
        read_s = 1'b1;
      end else begin
        read_s = 1'b0;
      end
    end else begin
      read_s = 1'b0;
    end
  end

  // Next-state logic for the run/pause/clear FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, PAUSE: begin
        if (clr_acc_s) begin
          state_nxt_s = CLEAR;
        end else if (ss_acc_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RUN: begin
        if (clr_acc_s) begin
          state_nxt_s = CLEAR;
        end else if (ss_acc_s) begin
          state_nxt_s = PAUSE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      CLEAR:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Recall pointer advances and wraps at the number of stored laps.
  always_comb begin
    if (({1'b0, rd_ptr_r} + CNT_ONE) == lap_count_r) begin
      rd_ptr_nxt_s = PTR_ZERO;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end
  end

  // Stopwatch command decoded straight from the FSM state.
  always_comb begin
    case (state_r)
      IDLE:    comanda = 2'b00;
      RUN:     comanda = 2'b01;
      PAUSE:   comanda = 2'b11;
      CLEAR:   comanda = 2'b10;
      default: comanda = 2'b00;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pointers, lap counter and registered recall/drop outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      lap_count_r <= CNT_ZERO;
      lap_s_r     <= 8'd0;
      lap_m_r     <= 8'd0;
      lap_idx_r   <= PTR_ZERO;
      lap_valid_r <= 1'b0;
      lap_drop_r  <= 1'b0;
    end else begin
      lap_valid_r <= read_s;
      lap_drop_r  <= drop_s;
      if (clr_acc_s) begin
        wr_ptr_r    <= PTR_ZERO;
        rd_ptr_r    <= PTR_ZERO;
        lap_count_r <= CNT_ZERO;
      end else begin
        if (store_s) begin
          wr_ptr_r    <= wr_ptr_r + PTR_ONE;
          lap_count_r <= lap_count_r + CNT_ONE;
        end
        if (read_s) begin
          lap_s_r   <= rd_data_s[7:0];
          lap_m_r   <= rd_data_s[15:8];
          lap_idx_r <= rd_ptr_r;
          rd_ptr_r  <= rd_ptr_nxt_s;
        end
      end
    end
  end

  // Lap memory write port; contents survive a clear on purpose.
  always_ff @(posedge clk) begin
    if (store_s && !rst) begin
      mem_r[wr_ptr_r] <= {timp_m, timp_s};
    end
  end

  assign lap_s     = lap_s_r;
  assign lap_m     = lap_m_r;
  assign lap_idx   = lap_idx_r;
  assign lap_valid = lap_valid_r;
  assign lap_count = lap_count_r;
  assign full      = full_s;
  assign lap_drop  = lap_drop_r;

endmodule

// File: tb/tb_lap_ctrl.sv
// Self-checking bench for lap_ctrl: directed scenarios with literal
// expectations plus randomized button traffic against a queue-based model.
module tb_lap_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_start_stop = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0, btn_recall = 1'b0;
  logic [7:0]    timp_s = 8'd0, timp_m = 8'd0;
  logic [1:0]    comanda;
  logic [7:0]    lap_s, lap_m;
  logic [AW-1:0] lap_idx;
  logic          lap_valid, full, lap_drop;
  logic [AW:0]   lap_count;

  lap_ctrl #(.ADR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .btn_start_stop(btn_start_stop), .btn_lap(btn_lap),
    .btn_clear(btn_clear), .btn_recall(btn_recall),
    .timp_s(timp_s), .timp_m(timp_m),
    .comanda(comanda), .lap_s(lap_s), .lap_m(lap_m), .lap_idx(lap_idx),
    .lap_valid(lap_valid), .lap_count(lap_count), .full(full), .lap_drop(lap_drop)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  // Behavioural model: mode 0 idle, 1 run, 2 pause, 3 clear.
  int           m_mode = 0;
  logic [15:0]  m_laps[$];
  int           m_rd = 0;
  int           m_s = 0, m_m = 0, m_idx = 0;
  bit           m_valid = 1'b0, m_drop = 1'b0;

  function automatic int mode_cmd(int md);
    case (md)
      1:       return 1;
      2:       return 3;
      3:       return 2;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    m_valid = 1'b0;
    m_drop  = 1'b0;
    if (rst) begin
      m_mode = 0; m_laps.delete(); m_rd = 0; m_s = 0; m_m = 0; m_idx = 0;
    end else if (m_mode == 3) begin
      m_mode = 0;
    end else if (btn_clear) begin
      m_mode = 3; m_laps.delete(); m_rd = 0;
    end else if (btn_start_stop) begin
      m_mode = (m_mode == 1) ? 2 : 1;
    end else if (btn_lap) begin
      if (m_mode == 1) begin
        if (m_laps.size() < DEPTH) m_laps.push_back({timp_m, timp_s});
        else m_drop = 1'b1;
      end
    end else if (btn_recall) begin
      if (m_mode != 1 && m_laps.size() > 0) begin
        m_s = m_laps[m_rd][7:0];
        m_m = m_laps[m_rd][15:8];
        m_idx = m_rd;
        m_valid = 1'b1;
        m_rd = (m_rd + 1) % m_laps.size();
      end
    end
  endtask

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("comanda", comanda, mode_cmd(m_mode));
      chk("lap_valid", lap_valid, m_valid);
      chk("lap_drop", lap_drop, m_drop);
      chk("lap_count", lap_count, m_laps.size());
      chk("full", full, (m_laps.size() == DEPTH) ? 1 : 0);
      chk("lap_s", lap_s, m_s);
      chk("lap_m", lap_m, m_m);
      chk("lap_idx", lap_idx, m_idx);
    end
  end

  task automatic cyc(input bit r, input bit ss, input bit lp, input bit cl, input bit rc,
                     input int mm = 0, input int sc = 0);
    rst = r; btn_start_stop = ss; btn_lap = lp; btn_clear = cl; btn_recall = rc;
    timp_m = 8'(mm); timp_s = 8'(sc);
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    // Reset values
    chk("rst_comanda", comanda, 0);
    chk("rst_count", lap_count, 0);
    chk("rst_full", full, 0);
    chk("rst_valid", lap_valid, 0);
    // start/stop toggling
    cyc(0, 1, 0, 0, 0); chk("ss1_cmd", comanda, 1);
    cyc(0, 1, 0, 0, 0); chk("ss2_cmd", comanda, 3);
    cyc(0, 1, 0, 0, 0); chk("ss3_cmd", comanda, 1);
    // two laps then recall three times in PAUSE
    cyc(0, 0, 1, 0, 0, 0, 5);
    cyc(0, 0, 1, 0, 0, 1, 12); chk("two_laps_count", lap_count, 2);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("rc1_valid", lap_valid, 1); chk("rc1_s", lap_s, 5); chk("rc1_m", lap_m, 0); chk("rc1_idx", lap_idx, 0);
    cyc(0, 0, 0, 0, 1);
    chk("rc2_s", lap_s, 12); chk("rc2_m", lap_m, 1); chk("rc2_idx", lap_idx, 1);
    cyc(0, 0, 0, 0, 1);
    chk("rc3_s", lap_s, 5); chk("rc3_idx", lap_idx, 0);
    cyc(0, 0, 0, 0, 0);
    chk("hold_valid", lap_valid, 0); chk("hold_s", lap_s, 5);
    // clear beats lap in the same cycle
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 9, 9);
    chk("clr_cmd", comanda, 2); chk("clr_count", lap_count, 0);
    cyc(0, 0, 0, 0, 0); chk("clr_idle", comanda, 0);
    // recall with nothing stored
    cyc(0, 0, 0, 0, 1);
    chk("empty_valid", lap_valid, 0); chk("empty_s", lap_s, 5);
    // fill and overflow
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0, i, 10 + i);
      if (i == 3) begin
        chk("fill_count", lap_count, 4); chk("fill_full", full, 1); chk("fill_drop", lap_drop, 0);
      end
      if (i == 4) begin
        chk("ovf_drop", lap_drop, 1); chk("ovf_count", lap_count, 4);
      end
    end
    cyc(0, 0, 0, 0, 0); chk("drop_once", lap_drop, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    chk("wrap_idx", lap_idx, 0); chk("wrap_s", lap_s, 10);
    // reset coinciding with a recall pulse
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("rstrc_valid", lap_valid, 0); chk("rstrc_s", lap_s, 0);
    chk("rstrc_idx", lap_idx, 0); chk("rstrc_cmd", comanda, 0); chk("rstrc_count", lap_count, 0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
          $urandom_range(0, 99), $urandom_range(0, 60));
    end
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
